// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end sequencer for the pipelined MIPS core.
// Each cycle it chooses whether the PC advances, redirects or freezes, and
// drives the NPC block and the IF/ID register to match. Load-use and JR
// hazards insert N bubble cycles. Saturating counters record the bubble
// cycles and the flush cycles.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   imem_ready     instruction word for the current PC is available
//   id_valid       ID stage holds a real instruction
//   id_npcop       decoded NPCOp of the ID instruction
//   id_br_taken    branch compare result for the ID instruction
//   id_load_use    ID instruction depends on a load in EX
//   id_jr_dep      JR source register is not yet forwardable
//   imem_req       fetch request
//   pc_wr          NPC Wr / PC register enable
//   npc_op         NPC NPCOp select
//   iflush         NPC IFlush (taken-branch select)
//   ifid_wr        IF/ID write enable
//   ifid_flush     clear IF/ID to a bubble on this edge
//   idex_bubble    inject a bubble into ID/EX
//   stall_cnt      saturating count of idex_bubble cycles
//   flush_cnt      saturating count of ifid_flush cycles
module fetch_ctrl #(
  parameter int LD_STALL = 1,
  parameter int JR_STALL = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ready,
  input  logic             id_valid,
  input  logic [1:0]       id_npcop,
  input  logic             id_br_taken,
  input  logic             id_load_use,
  input  logic             id_jr_dep,
  output logic             imem_req,
  output logic             pc_wr,
  output logic [1:0]       npc_op,
  output logic             iflush,
  output logic             ifid_wr,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // NPCOp encodings shared with the NPC block.
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [2:0] LD_N  = 3'(LD_STALL);
  localparam logic [2:0] JR_N  = 3'(JR_STALL);
  localparam logic [2:0] MAX_N = (LD_STALL > JR_STALL) ? LD_N : JR_N;

  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;

  state_t     state, state_nxt;
  logic [2:0] scnt, scnt_nxt;
  logic       hz_mask, hz_mask_nxt;

  logic       ld_hz, jr_hz, hazard;
  logic [2:0] n_stall;

  // Hazard detection. hz_mask lets the instruction that was just stalled
  // issue even though its dependency inputs are still asserted.
  always_comb begin
    ld_hz   = id_load_use;
    jr_hz   = (id_npcop == NPC_JR) && id_jr_dep;
    hazard  = id_valid && !hz_mask && (ld_hz || jr_hz);
    n_stall = ld_hz ? (jr_hz ? MAX_N : LD_N) : JR_N;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      scnt    <= 3'd0;
      hz_mask <= 1'b0;
    end else begin
      state   <= state_nxt;
      scnt    <= scnt_nxt;
      hz_mask <= hz_mask_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    scnt_nxt    = scnt;
    hz_mask_nxt = hz_mask;
    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        // A freeze (imem_ready=0) holds everything, including hz_mask.
        if (imem_ready) begin
          if (hazard) begin
            // The current cycle is bubble 1; STALL supplies the remaining
            // N-1 bubbles, ending when scnt reaches 0.
            if (n_stall == 3'd1) begin
              hz_mask_nxt = 1'b1;
            end else begin
              state_nxt = STALL;
              scnt_nxt  = n_stall - 3'd2;
            end
          end else begin
            hz_mask_nxt = 1'b0;
          end
        end
      end
      STALL: begin
        if (scnt != 3'd0) begin
          scnt_nxt = scnt - 3'd1;
        end else begin
          state_nxt   = RUN;
          hz_mask_nxt = 1'b1;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Output logic: combinational, so NPC/PC act on the decision this cycle.
  always_comb begin
    imem_req    = 1'b0;
    pc_wr       = 1'b0;
    npc_op      = NPC_PLUS4;
    iflush      = 1'b0;
    ifid_wr     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          imem_req = 1'b1;
          if (!imem_ready || hazard) begin
            // Freeze or hazard bubble: a pending redirect stays unresolved.
            idex_bubble = 1'b1;
          end else begin
            pc_wr   = 1'b1;
            ifid_wr = 1'b1;
            if (id_valid) begin
              npc_op     = id_npcop;
              iflush     = (id_npcop == NPC_BRANCH) && id_br_taken;
              // Redirect: the sequential word latched this edge is wrong-path.
              ifid_flush = (id_npcop == NPC_JUMP) || (id_npcop == NPC_JR) ||
                           ((id_npcop == NPC_BRANCH) && id_br_taken);
            end
          end
        end
        STALL:   idex_bubble = 1'b1;
        default: ;
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (idex_bubble && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ifid_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl. Two instances share one stimulus stream:
//   a: LD_STALL=1, JR_STALL=2, CNT_W=16
//   b: LD_STALL=3, JR_STALL=7, CNT_W=2
// A cycle-level reference model (one per instance) predicts every output;
// directed steps follow the test plan, then a randomized phase runs.
module tb_fetch_ctrl;

  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_ready, id_valid, id_br_taken, id_load_use, id_jr_dep;
  logic [1:0] id_npcop;

  always #5 clk = ~clk;

  typedef struct packed {
    logic        imem_req;
    logic        pc_wr;
    logic [1:0]  npc_op;
    logic        iflush;
    logic        ifid_wr;
    logic        ifid_flush;
    logic        idex_bubble;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
  } out_t;

  // Model state: boot cycle flag, bubbles still owed by the current hazard,
  // mask flag, and the two counter values.
  typedef struct {
    bit boot;
    int pend;
    bit mask;
    int sc;
    int fc;
  } model_t;

  // DUT a
  logic        a_imem_req, a_pc_wr, a_iflush, a_ifid_wr, a_ifid_flush, a_idex_bubble;
  logic [1:0]  a_npc_op;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  // DUT b
  logic        b_imem_req, b_pc_wr, b_iflush, b_ifid_wr, b_ifid_flush, b_idex_bubble;
  logic [1:0]  b_npc_op;
  logic [1:0]  b_stall_cnt, b_flush_cnt;

  fetch_ctrl #(.LD_STALL(1), .JR_STALL(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .id_valid(id_valid),
    .id_npcop(id_npcop), .id_br_taken(id_br_taken), .id_load_use(id_load_use),
    .id_jr_dep(id_jr_dep), .imem_req(a_imem_req), .pc_wr(a_pc_wr),
    .npc_op(a_npc_op), .iflush(a_iflush), .ifid_wr(a_ifid_wr),
    .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  fetch_ctrl #(.LD_STALL(3), .JR_STALL(7), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .imem_ready(imem_ready), .id_valid(id_valid),
    .id_npcop(id_npcop), .id_br_taken(id_br_taken), .id_load_use(id_load_use),
    .id_jr_dep(id_jr_dep), .imem_req(b_imem_req), .pc_wr(b_pc_wr),
    .npc_op(b_npc_op), .iflush(b_iflush), .ifid_wr(b_ifid_wr),
    .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  out_t obs_a, obs_b;
  always_comb begin
    obs_a = '{a_imem_req, a_pc_wr, a_npc_op, a_iflush, a_ifid_wr, a_ifid_flush,
              a_idex_bubble, a_stall_cnt, a_flush_cnt};
    obs_b = '{b_imem_req, b_pc_wr, b_npc_op, b_iflush, b_ifid_wr, b_ifid_flush,
              b_idex_bubble, 16'(b_stall_cnt), 16'(b_flush_cnt)};
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string name, input out_t o, input out_t e);
    check({name, ".imem_req"},    16'(o.imem_req),    16'(e.imem_req));
    check({name, ".pc_wr"},       16'(o.pc_wr),       16'(e.pc_wr));
    check({name, ".npc_op"},      16'(o.npc_op),      16'(e.npc_op));
    check({name, ".iflush"},      16'(o.iflush),      16'(e.iflush));
    check({name, ".ifid_wr"},     16'(o.ifid_wr),     16'(e.ifid_wr));
    check({name, ".ifid_flush"},  16'(o.ifid_flush),  16'(e.ifid_flush));
    check({name, ".idex_bubble"}, 16'(o.idex_bubble), 16'(e.idex_bubble));
    check({name, ".stall_cnt"},   o.stall_cnt,        e.stall_cnt);
    check({name, ".flush_cnt"},   o.flush_cnt,        e.flush_cnt);
  endtask

  function automatic bit model_hazard(input model_t m);
    return id_valid && !m.mask && (id_load_use || (id_npcop == NPC_JR && id_jr_dep));
  endfunction

  // Predicted outputs for the current cycle.
  function automatic out_t model_out(input model_t m);
    out_t e;
    e = '0;
    e.npc_op    = NPC_PLUS4;
    e.stall_cnt = 16'(m.sc);
    e.flush_cnt = 16'(m.fc);
    if (rst || m.boot) return e;
    if (m.pend > 0) begin
      e.idex_bubble = 1'b1;
      return e;
    end
    e.imem_req = 1'b1;
    if (!imem_ready || model_hazard(m)) begin
      e.idex_bubble = 1'b1;
    end else begin
      bit taken;
      taken     = id_valid && id_npcop == NPC_BRANCH && id_br_taken;
      e.pc_wr   = 1'b1;
      e.ifid_wr = 1'b1;
      if (id_valid) e.npc_op = id_npcop;
      e.iflush     = taken;
      e.ifid_flush = taken || (id_valid && (id_npcop == NPC_JUMP || id_npcop == NPC_JR));
    end
    return e;
  endfunction

  // Model state after the clock edge.
  function automatic model_t model_next(input model_t m, input out_t e,
                                        input int ld_n, input int jr_n, input int cmax);
    model_t n;
    n = m;
    if (rst) begin
      n = '{boot: 1'b1, pend: 0, mask: 1'b0, sc: 0, fc: 0};
      return n;
    end
    if (e.idex_bubble && n.sc < cmax) n.sc++;
    if (e.ifid_flush && n.fc < cmax) n.fc++;
    if (m.boot) begin
      n.boot = 1'b0;
    end else if (m.pend > 0) begin
      n.pend--;
      if (n.pend == 0) n.mask = 1'b1;
    end else if (imem_ready) begin
      if (model_hazard(m)) begin
        int bubbles;
        bit jr;
        jr = (id_npcop == NPC_JR) && id_jr_dep;
        if (id_load_use && jr) bubbles = (ld_n > jr_n) ? ld_n : jr_n;
        else if (id_load_use)  bubbles = ld_n;
        else                   bubbles = jr_n;
        if (bubbles == 1) n.mask = 1'b1;
        else              n.pend = bubbles - 1;
      end else begin
        n.mask = 1'b0;
      end
    end
    return n;
  endfunction

  model_t ma, mb;

  // One cycle: let inputs settle, compare both instances, clock, advance models.
  task automatic tick();
    out_t ea, eb;
    #2;
    ea = model_out(ma);
    eb = model_out(mb);
    check_all("a", obs_a, ea);
    check_all("b", obs_b, eb);
    @(posedge clk);
    ma = model_next(ma, ea, 1, 2, 65535);
    mb = model_next(mb, eb, 3, 7, 3);
    #1;
  endtask

  task automatic set_in(input logic rdy, input logic vld, input logic [1:0] op,
                        input logic tkn, input logic lu, input logic jd);
    imem_ready  = rdy;
    id_valid    = vld;
    id_npcop    = op;
    id_br_taken = tkn;
    id_load_use = lu;
    id_jr_dep   = jd;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1, 0, NPC_PLUS4, 0, 0, 0);
    // Control outputs are forced low by rst even before the first edge.
    #2;
    check("a.rst_pc_wr", 16'(a_pc_wr), 16'd0);
    check("b.rst_imem_req", 16'(b_imem_req), 16'd0);
    @(posedge clk);
    ma = '{boot: 1'b1, pend: 0, mask: 1'b0, sc: 0, fc: 0};
    mb = ma;
    #1;

    // Reset: two cycles held, then BOOT, then the first fetch.
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Taken branch, then not-taken branch.
    set_in(1, 1, NPC_BRANCH, 1, 0, 0);
    tick();
    check("a.flush_cnt_after_taken", a_flush_cnt, 16'd1);
    set_in(1, 1, NPC_BRANCH, 0, 0, 0);
    tick();
    check("a.flush_cnt_after_not_taken", a_flush_cnt, 16'd1);

    // Load-use held: one bubble on a, then issue despite id_load_use=1.
    set_in(1, 1, NPC_PLUS4, 0, 1, 0);
    tick();
    tick();
    check("a.ld_stall_cnt", a_stall_cnt, 16'd1);
    set_in(1, 0, NPC_PLUS4, 0, 0, 0);
    repeat (3) tick();

    // JR with unresolved source: two bubbles on a, then the JR redirect.
    set_in(1, 1, NPC_JR, 0, 0, 1);
    repeat (3) tick();
    set_in(1, 0, NPC_PLUS4, 0, 0, 0);
    repeat (6) tick();

    // Pending taken branch while imem is not ready for 3 cycles.
    set_in(0, 1, NPC_BRANCH, 1, 0, 0);
    repeat (3) tick();
    set_in(1, 1, NPC_BRANCH, 1, 0, 0);
    tick();
    check("a.pending_stall_cnt", a_stall_cnt, 16'd6);
    check("a.pending_flush_cnt", a_flush_cnt, 16'd3);

    // Five freeze bubbles: the 2-bit counter on b stays saturated at 3.
    set_in(0, 0, NPC_PLUS4, 0, 0, 0);
    repeat (5) tick();
    check("b.stall_cnt_sat", 16'(b_stall_cnt), 16'd3);

    // Reset during b's 7-cycle JR stall.
    set_in(1, 1, NPC_JR, 0, 0, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_in(1, 0, NPC_PLUS4, 0, 0, 0);
    check("b.boot_stall_cnt", 16'(b_stall_cnt), 16'd0);
    check("b.boot_flush_cnt", 16'(b_flush_cnt), 16'd0);
    tick();
    tick();

    // Randomized phase with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      imem_ready  = ($urandom_range(0, 3) != 0);
      id_valid    = ($urandom_range(0, 4) != 0);
      id_npcop    = 2'($urandom_range(0, 3));
      id_br_taken = 1'($urandom);
      id_load_use = ($urandom_range(0, 4) == 0);
      id_jr_dep   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
